timer_irq_unit: RTL and testbench
=================================

Name: timer_irq_unit

Overview:
- Memory-mapped timer peripheral on the single-cycle MIPS data bus.
- Generates the Interrupt input consumed directly by the CPU control decoder.
- Holds a reload register (TH), an up-counter (TL), a control/status register (TCON) and a free-running cycle counter (SYSTICK).
- The CPU programs and acknowledges the timer through lw/sw at fixed addresses.

Parameters:
- BASE_ADDR, 32'h40000000, word address of TH; TL = BASE+4, TCON = BASE+8, SYSTICK = BASE+12.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- addr  input  32  byte address from ALU result; bits [1:0] ignored.
- wdata  input  32  store data (rt value).
- MemRd  input  1  read strobe from control.
- MemWr  input  1  write strobe from control.
- rdata  output  32  read data, combinational.
- Interrupt  output  1  timer interrupt request to control (level).
- tcon  output  3  current TCON value, for debug/LED.

Behaviour:
- Reset (reset=0, asynchronous): TH=0, TL=0, TCON=3'b000, SYSTICK=0. Outputs follow immediately: Interrupt=0, tcon=0, rdata=0.
- TCON bit assignments:
  - [0] count enable.
  - [1] interrupt enable.
  - [2] interrupt status (sticky).
- Interrupt = TCON[1] & TCON[2], taken directly from flops. No combinational path from addr/wdata to Interrupt.
- Hit decode: hit_X = (addr[31:2] == X[31:2]).
- Write: when MemWr=1 and the address hits, the register is loaded with wdata at the next edge. TCON takes wdata[2:0]; SYSTICK writes are ignored.
- Read: when MemRd=1 and the address hits, rdata = register value (TCON zero-extended). Otherwise rdata = 0. Unmapped addresses read 0 and writes to them have no effect.
- SYSTICK: increments by 1 every cycle, wraps FFFFFFFF -> 0.
- Counting: when TCON[0]=1 and TL != 32'hFFFFFFFF, TL <= TL+1.
- Overflow: when TCON[0]=1 and TL == 32'hFFFFFFFF:
  - TL <= TH (reload, not 0).
  - If TCON[1]=1, TCON[2] <= 1.
  - If TCON[1]=0, status is unchanged.
- Latency: Interrupt rises in the cycle after the overflow edge, i.e. together with TL showing TH.
- Acknowledge: the CPU clears status by writing TCON with bit2=0. Interrupt drops one edge later.
- Simultaneous events:
  - CPU write to TL in the same cycle as increment/overflow: the write wins, with no reload and no increment. The status set from that overflow is suppressed.
  - CPU write to TCON in the same cycle as an overflow that would set status: TCON[1:0] = wdata[1:0]; TCON[2] = wdata[2] | (wdata[1] & overflow), so a pending interrupt is not lost when the ISR acks.
  - CPU write to TH in the same cycle as a reload: TL reloads the old TH; the new TH is used from the next reload.
  - Enable cleared by a write during overflow: the overflow still completes (reload/status) in that edge.
- TH == FFFFFFFF with enable: overflow every cycle; status stays 1.
- Reset asserted mid-count: everything clears asynchronously. Counting resumes only after software re-enables.
- Writes with MemRd and MemWr both high: the write occurs and rdata shows the pre-write value.

Test Plan:
- Reset: hold reset=0 with random bus activity -> rdata=0, Interrupt=0, tcon=0. Release, then read SYSTICK after 5 cycles -> 5 (±1 for the read-cycle convention, which the bench fixes as 5).
- Reload/IRQ: write TH=FFFFFFF0, TL=FFFFFFFE, TCON=3 -> TL=FFFFFFFF after 1 edge. After 2 edges TL=FFFFFFF0, tcon=3'b111, Interrupt=1. Then TL=FFFFFFF1 on the next edge.
- Ack: with Interrupt=1, write TCON=3 -> Interrupt=0 after 1 edge, counting continues. Next overflow after 16 cycles -> Interrupt=1.
- Masked: TCON=1, force overflow -> TL reloads to TH, tcon[2]=0, Interrupt=0 throughout.
- Collisions:
  - Write TCON=3 exactly on the overflow edge -> tcon=3'b111, Interrupt=1.
  - Write TL=5 exactly on the overflow edge -> TL=5, tcon[2]=0.
- Decode: read BASE+16 and BASE+8 with MemRd=0 -> rdata=0. sw to SYSTICK=1234 -> SYSTICK unaffected.

Source files
------------

// File: rtl/timer_irq_unit.sv
// timer_irq_unit: memory-mapped reload timer with sticky interrupt status and a free-running cycle counter.
module timer_irq_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRd,
    input  logic        MemWr,
    output logic [31:0] rdata,
    output logic        Interrupt,
    output logic [2:0]  tcon
);
    localparam logic [31:0] TL_ADDR   = BASE_ADDR + 32'd4;
    localparam logic [31:0] TCON_ADDR = BASE_ADDR + 32'd8;
    localparam logic [31:0] TICK_ADDR = BASE_ADDR + 32'd12;

    logic [31:0] r_th, r_tl, r_tick;
    logic [2:0]  r_tcon;
    logic        w_hit_th, w_hit_tl, w_hit_tcon, w_hit_tick;
    logic        w_wr_th, w_wr_tl, w_wr_tcon, w_ovf;

    assign w_hit_th   = addr[31:2] == BASE_ADDR[31:2];
    assign w_hit_tl   = addr[31:2] == TL_ADDR[31:2];
    assign w_hit_tcon = addr[31:2] == TCON_ADDR[31:2];
    assign w_hit_tick = addr[31:2] == TICK_ADDR[31:2];
    assign w_wr_th    = MemWr & w_hit_th;
    assign w_wr_tl    = MemWr & w_hit_tl;
    assign w_wr_tcon  = MemWr & w_hit_tcon;
    // A software TL write overrides the overflow entirely, including its status set.
    assign w_ovf      = r_tcon[0] & (r_tl == 32'hFFFFFFFF) & ~w_wr_tl;

    assign Interrupt = r_tcon[1] & r_tcon[2];
    assign tcon      = r_tcon;

    always_comb begin
        rdata = 32'd0;
        if (MemRd)
            rdata = w_hit_th   ? r_th :
                    w_hit_tl   ? r_tl :
                    w_hit_tcon ? {29'd0, r_tcon} :
                    w_hit_tick ? r_tick : 32'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th   <= 32'd0;
            r_tl   <= 32'd0;
            r_tcon <= 3'b000;
            r_tick <= 32'd0;
        end else begin
            r_tick <= r_tick + 32'd1;
            if (w_wr_th)
                r_th <= wdata;
            if (w_wr_tl)
                r_tl <= wdata;
            else if (r_tcon[0])
                r_tl <= w_ovf ? r_th : r_tl + 32'd1;
            // An ack landing on an overflow keeps the new status so the pending interrupt survives.
            if (w_wr_tcon)
                r_tcon <= {wdata[2] | (wdata[1] & w_ovf), wdata[1:0]};
            else if (w_ovf & r_tcon[1])
                r_tcon[2] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_timer_irq_unit.sv
// tb_timer_irq_unit: directed bench for the timer peripheral with hand-computed expectations.
module tb_timer_irq_unit;
    localparam logic [31:0] TH   = 32'h40000000;
    localparam logic [31:0] TL   = 32'h40000004;
    localparam logic [31:0] TCON = 32'h40000008;
    localparam logic [31:0] TICK = 32'h4000000C;

    logic        clk = 1'b0, reset = 1'b0, MemRd = 1'b0, MemWr = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0, rdata, v;
    logic        Interrupt;
    logic [2:0]  tcon;
    int          n_chk = 0, n_err = 0;

    timer_irq_unit dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .MemRd(MemRd),
        .MemWr(MemWr), .rdata(rdata), .Interrupt(Interrupt), .tcon(tcon)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; MemWr = 1'b1; MemRd = 1'b0;
        @(negedge clk);
        MemWr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; MemRd = 1'b1;
        #1 d = rdata;
        MemRd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addr = TH + 32'($urandom_range(0, 3) * 4); wdata = $urandom;
            MemRd = 1'b1; MemWr = 1'($urandom_range(0, 1));
            #1;
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_irq", {31'd0, Interrupt}, 32'd0);
            chk("rst_tcon", {29'd0, tcon}, 32'd0);
        end
        @(negedge clk);
        MemRd = 1'b0; MemWr = 1'b0; reset = 1'b1;
        idle(5);
        rd(TICK, v); chk("systick5", v, 32'd5);

        wr(TH, 32'hFFFFFFF0);
        wr(TL, 32'hFFFFFFFE);
        wr(TCON, 32'd3);
        rd(TL, v); chk("tl_armed", v, 32'hFFFFFFFE);
        idle(1); rd(TL, v); chk("tl_max", v, 32'hFFFFFFFF);
        idle(1); rd(TL, v); chk("tl_reload", v, 32'hFFFFFFF0);
        chk("tcon_irq", {29'd0, tcon}, 32'd7);
        chk("irq_set", {31'd0, Interrupt}, 32'd1);
        idle(1); rd(TL, v); chk("tl_after", v, 32'hFFFFFFF1);

        wr(TCON, 32'd3);
        chk("ack_irq", {31'd0, Interrupt}, 32'd0);
        rd(TL, v); chk("ack_count", v, 32'hFFFFFFF2);
        idle(13);
        chk("pre_ovf_irq", {31'd0, Interrupt}, 32'd0);
        idle(1);
        chk("ovf2_irq", {31'd0, Interrupt}, 32'd1);
        rd(TL, v); chk("ovf2_tl", v, 32'hFFFFFFF0);

        wr(TCON, 32'd1);
        wr(TL, 32'hFFFFFFFF);
        idle(1); rd(TL, v); chk("mask_tl", v, 32'hFFFFFFF0);
        chk("mask_tcon", {29'd0, tcon}, 32'd1);
        chk("mask_irq", {31'd0, Interrupt}, 32'd0);

        wr(TL, 32'hFFFFFFFE);
        idle(1);
        wr(TCON, 32'd3);
        chk("col_tcon", {29'd0, tcon}, 32'd7);
        chk("col_tcon_irq", {31'd0, Interrupt}, 32'd1);

        wr(TCON, 32'd3);
        wr(TL, 32'hFFFFFFFF);
        wr(TL, 32'd5);
        rd(TL, v); chk("col_tl", v, 32'd5);
        chk("col_tl_tcon", {29'd0, tcon}, 32'd3);

        wr(TL, 32'hFFFFFFFF);
        wr(TH, 32'h100);
        rd(TL, v); chk("col_th_tl", v, 32'hFFFFFFF0);
        rd(TH, v); chk("col_th_th", v, 32'h100);

        addr = TCON; MemRd = 1'b0; #1;
        chk("nord_rdata", rdata, 32'd0);
        rd(TH + 32'd16, v); chk("unmapped_rd", v, 32'd0);
        wr(TH + 32'd16, 32'hDEADBEEF);
        rd(TH, v); chk("unmapped_wr", v, 32'h100);
        rd(TICK, v);
        wr(TICK, 32'd1234);
        rd(TICK, wdata); chk("tick_ro", wdata, v + 32'd1);

        addr = TH; wdata = 32'h200; MemRd = 1'b1; MemWr = 1'b1; #1;
        chk("rdwr_old", rdata, 32'h100);
        @(negedge clk);
        MemWr = 1'b0; #1;
        chk("rdwr_new", rdata, 32'h200);
        MemRd = 1'b0;

        wr(TH, 32'hFFFFFFFF);
        wr(TL, 32'hFFFFFFFF);
        idle(3);
        rd(TL, v); chk("th_max_tl", v, 32'hFFFFFFFF);
        chk("th_max_tcon", {29'd0, tcon}, 32'd7);

        #2 reset = 1'b0;
        addr = TL; MemRd = 1'b1; #1;
        chk("async_rdata", rdata, 32'd0);
        chk("async_tcon", {29'd0, tcon}, 32'd0);
        chk("async_irq", {31'd0, Interrupt}, 32'd0);
        MemRd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        rd(TL, v); chk("no_resume", v, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
